// File: rtl/regfile_sb.sv
// Multi-port integer register file with write-to-read bypass, pending-write
// scoreboard and a sequenced clear sweep that runs after every reset.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREAD*AW-1:0]   ra,
    output logic [NREAD*XLEN-1:0] rd,
    output logic [NREAD-1:0]      rs_busy,
    input  logic                  we,
    input  logic [AW-1:0]         wa,
    input  logic [XLEN-1:0]       wd,
    input  logic                  alloc_valid,
    input  logic [AW-1:0]         alloc_addr,
    output logic                  ready
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t          state;
    logic [AW-1:0]   cnt;
    logic [NREGS-1:0] busy;
    logic [XLEN-1:0] regs [NREGS];

    logic run;
    logic wr_en;
    logic al_en;

    assign run   = (state == RUN);
    assign wr_en = run && we && (wa != '0);
    assign al_en = run && alloc_valid && (alloc_addr != '0);

    // Control: sweep sequencing, ready flag and busy scoreboard.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == AW'(NREGS - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    // Alloc is applied last so a same-cycle alloc wins over the release.
                    if (wr_en) busy[wa] <= 1'b0;
                    if (al_en) busy[alloc_addr] <= 1'b1;
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Storage: zeroed one entry per cycle during the sweep, written only in RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                regs[cnt] <= '0;
            end else if (wr_en) begin
                regs[wa] <= wd;
            end
        end
    end

    // Register 0 and the whole CLEAR phase read as zero and never busy.
    always_comb begin
        rd      = '0;
        rs_busy = '0;
        for (int i = 0; i < NREAD; i++) begin
            if (run && (ra[i*AW +: AW] != '0)) begin
                if ((BYPASS != 0) && we && (wa == ra[i*AW +: AW])) begin
                    rd[i*XLEN +: XLEN] = wd;
                end else begin
                    rd[i*XLEN +: XLEN] = regs[ra[i*AW +: AW]];
                end
                rs_busy[i] = busy[ra[i*AW +: AW]];
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default build, a no-bypass build sharing its
// inputs, and a 64-bit / 16-register / 4-port build.
module tb_regfile_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [9:0]  ra_a;
    logic [63:0] rd_a;
    logic [63:0] rd_b;
    logic [1:0]  rs_busy_a;
    logic [1:0]  rs_busy_b;
    logic        we_a;
    logic [4:0]  wa_a;
    logic [31:0] wd_a;
    logic        alloc_valid_a;
    logic [4:0]  alloc_addr_a;
    logic        ready_a;
    logic        ready_b;

    logic [15:0]  ra_c;
    logic [255:0] rd_c;
    logic [3:0]   rs_busy_c;
    logic         we_c;
    logic [3:0]   wa_c;
    logic [63:0]  wd_c;
    logic         alloc_valid_c;
    logic [3:0]   alloc_addr_c;
    logic         ready_c;

    regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .ra(ra_a), .rd(rd_a), .rs_busy(rs_busy_a),
        .we(we_a), .wa(wa_a), .wd(wd_a), .alloc_valid(alloc_valid_a),
        .alloc_addr(alloc_addr_a), .ready(ready_a)
    );

    regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .ra(ra_a), .rd(rd_b), .rs_busy(rs_busy_b),
        .we(we_a), .wa(wa_a), .wd(wd_a), .alloc_valid(alloc_valid_a),
        .alloc_addr(alloc_addr_a), .ready(ready_b)
    );

    regfile_sb #(.XLEN(64), .NREGS(16), .NREAD(4), .BYPASS(1)) dut_c (
        .clk(clk), .rst(rst), .ra(ra_c), .rd(rd_c), .rs_busy(rs_busy_c),
        .we(we_c), .wa(wa_c), .wd(wd_c), .alloc_valid(alloc_valid_c),
        .alloc_addr(alloc_addr_c), .ready(ready_c)
    );

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sbq.push_back(e);
    endtask

    task automatic check(input logic [63:0] obs);
        exp_t e;
        e = sbq.pop_front();
        checks++;
        assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] cval(input int i);
        return {32'hA5A5_0000 | 32'(i), 32'h5A5A_0000 | 32'(i << 8)};
    endfunction

    int n;
    int c_rise;

    initial begin
        rst = 1'b1;
        ra_a = '0; we_a = 1'b0; wa_a = '0; wd_a = '0;
        alloc_valid_a = 1'b0; alloc_addr_a = '0;
        ra_c = '0; we_c = 1'b0; wa_c = '0; wd_c = '0;
        alloc_valid_c = 1'b0; alloc_addr_c = '0;
        tick();
        tick();

        // Sweep: writes attempted while clearing must be ignored.
        rst = 1'b0;
        ra_a[4:0] = 5'd5; we_a = 1'b1; wa_a = 5'd5; wd_a = 32'hAA;
        #1;
        push("clear_ready", 64'd0);      check(64'(ready_a));
        push("clear_rd0", 64'd0);        check(64'(rd_a[31:0]));
        push("clear_busy", 64'd0);       check(64'(rs_busy_a));
        n = 0; c_rise = 0;
        while (!ready_a && n < 100) begin
            tick();
            n++;
            if (n == 20) we_a = 1'b0;
            if (ready_c && c_rise == 0) c_rise = n;
        end
        push("sweep_len_32", 64'd32);    check(64'(n));
        push("sweep_len_16", 64'd16);    check(64'(c_rise));
        push("after_sweep_rd5", 64'd0);  check(64'(rd_a[31:0]));
        push("after_sweep_rd5_nb", 64'd0); check(64'(rd_b[31:0]));

        // Write with same-cycle bypass (and old value on the no-bypass build).
        we_a = 1'b1; wa_a = 5'd3; wd_a = 32'hDEADBEEF; ra_a[4:0] = 5'd3;
        #1;
        push("bypass_rd0", 64'hDEADBEEF); check(64'(rd_a[31:0]));
        push("nobypass_rd0", 64'd0);      check(64'(rd_b[31:0]));
        tick();
        we_a = 1'b0; ra_a[9:5] = 5'd3;
        #1;
        push("stored_rd1", 64'hDEADBEEF);    check(64'(rd_a[63:32]));
        push("stored_rd1_nb", 64'hDEADBEEF); check(64'(rd_b[63:32]));

        // Register 0 ignores writes, allocs and bypass.
        ra_a = '0; we_a = 1'b1; wa_a = 5'd0; wd_a = 32'hFFFFFFFF;
        alloc_valid_a = 1'b1; alloc_addr_a = 5'd0;
        #1;
        push("x0_rd_same", 64'd0);   check(rd_a);
        push("x0_busy_same", 64'd0); check(64'(rs_busy_a));
        tick();
        we_a = 1'b0; alloc_valid_a = 1'b0;
        #1;
        push("x0_rd_next", 64'd0);   check(rd_a);
        push("x0_busy_next", 64'd0); check(64'(rs_busy_a));

        // Scoreboard set, release and same-cycle alloc+write.
        ra_a[4:0] = 5'd7; alloc_valid_a = 1'b1; alloc_addr_a = 5'd7;
        #1;
        push("alloc_busy_same", 64'd0); check(64'(rs_busy_a[0]));
        tick();
        alloc_valid_a = 1'b0;
        #1;
        push("alloc_busy_next", 64'd1); check(64'(rs_busy_a[0]));
        we_a = 1'b1; wa_a = 5'd7; wd_a = 32'h1234;
        #1;
        push("wr_busy_same", 64'd1);     check(64'(rs_busy_a[0]));
        push("wr_bypass", 64'h1234);     check(64'(rd_a[31:0]));
        tick();
        we_a = 1'b0;
        #1;
        push("wr_busy_next", 64'd0);     check(64'(rs_busy_a[0]));
        push("wr_rd_next", 64'h1234);    check(64'(rd_a[31:0]));
        we_a = 1'b1; wa_a = 5'd7; wd_a = 32'h55;
        alloc_valid_a = 1'b1; alloc_addr_a = 5'd7;
        tick();
        we_a = 1'b0; alloc_valid_a = 1'b0;
        #1;
        push("both_busy", 64'd1);        check(64'(rs_busy_a[0]));
        push("both_rd", 64'h55);         check(64'(rd_a[31:0]));
        we_a = 1'b1; wa_a = 5'd7; wd_a = 32'h66;
        alloc_valid_a = 1'b1; alloc_addr_a = 5'd8;
        tick();
        we_a = 1'b0; alloc_valid_a = 1'b0; ra_a[9:5] = 5'd8;
        #1;
        push("split_busy", 64'b10);      check(64'(rs_busy_a));
        push("split_rd7", 64'h66);       check(64'(rd_a[31:0]));
        ra_a[9:5] = 5'd7;
        #1;
        push("same_addr_ports", {32'h66, 32'h66}); check(rd_a);

        // Mid-operation reset.
        ra_a = {5'd0, 5'd9};
        we_a = 1'b1; wa_a = 5'd9; wd_a = 32'h77;
        tick();
        we_a = 1'b0; alloc_valid_a = 1'b1; alloc_addr_a = 5'd9;
        tick();
        alloc_valid_a = 1'b0;
        #1;
        push("pre_rst_busy", 64'd1);     check(64'(rs_busy_a[0]));
        push("pre_rst_rd", 64'h77);      check(64'(rd_a[31:0]));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        push("rst_busy", 64'd0);         check(64'(rs_busy_a[0]));
        push("rst_ready", 64'd0);        check(64'(ready_a));
        n = 0;
        while (!ready_a && n < 100) begin
            tick();
            n++;
        end
        push("resweep_len", 64'd32);     check(64'(n));
        push("resweep_rd9", 64'd0);      check(64'(rd_a[31:0]));
        push("resweep_busy9", 64'd0);    check(64'(rs_busy_a[0]));

        // Wide build: four ports, distinct 64-bit values.
        push("c_ready", 64'd1);          check(64'(ready_c));
        for (int i = 1; i < 16; i++) begin
            we_c = 1'b1; wa_c = 4'(i); wd_c = cval(i);
            tick();
        end
        we_c = 1'b0;
        ra_c[3:0] = 4'd9; ra_c[7:4] = 4'd15; ra_c[11:8] = 4'd2; ra_c[15:12] = 4'd13;
        #1;
        push("c_p0", cval(9));           check(rd_c[63:0]);
        push("c_p1", cval(15));          check(rd_c[127:64]);
        push("c_p2", cval(2));           check(rd_c[191:128]);
        push("c_p3", cval(13));          check(rd_c[255:192]);
        ra_c[3:0] = 4'd0; ra_c[7:4] = 4'd8; ra_c[11:8] = 4'd1; ra_c[15:12] = 4'd1;
        #1;
        push("c_p0_x0", 64'd0);          check(rd_c[63:0]);
        push("c_p1_b", cval(8));         check(rd_c[127:64]);
        push("c_p2_b", cval(1));         check(rd_c[191:128]);
        push("c_p3_b", cval(1));         check(rd_c[255:192]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
